// File: rtl/ed25519_pkg.sv
// Shared definitions for the ed25519 64-bit stream front end and back end.
// Holds the stream/coordinate widths, the serializer state encoding, the
// word-counter type and the packed layout of a padded affine point.
package ed25519_pkg;

    localparam int unsigned WORD_W          = 64;
    localparam int unsigned COORD_W         = 255;
    localparam int unsigned WORDS_PER_COORD = 4;
    localparam int unsigned WORDS_PER_POINT = 2 * WORDS_PER_COORD;
    localparam int unsigned POINT_W         = WORD_W * WORDS_PER_POINT;
    localparam int unsigned CNT_W           = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    typedef logic [CNT_W-1:0] word_cnt_t;

    localparam word_cnt_t LAST_WORD = word_cnt_t'(WORDS_PER_POINT - 1);

    // Each coordinate is zero-padded to 256 bits; x occupies the low half so
    // it leaves first, least-significant word first.
    typedef struct packed {
        logic               y_pad;
        logic [COORD_W-1:0] y;
        logic               x_pad;
        logic [COORD_W-1:0] x;
    } point_t;

endpackage

// File: rtl/point_serializer.sv
// point_serializer: latches one reduced affine point (x, y) from the reducer
// and streams it out as eight 64-bit words, x first, LSW first, each
// coordinate zero-padded to 256 bits.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_red_valid/o_red_ready  point handshake from the reducer
//   i_red_x, i_red_y         affine coordinates, sampled on the accept edge
//   o_out_valid/i_out_ready  word handshake to the output pins
//   o_out_data               current output word
//
// Build option SER_BACK2BACK_EN: when defined, a new point may be accepted on
// the same edge as the last word of the previous one, removing the idle
// bubble between points (o_red_ready then follows i_out_ready on the last
// word). Undefined: o_red_ready is a pure state decode.
module point_serializer
    import ed25519_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_red_valid,
    output logic               o_red_ready,
    input  logic [COORD_W-1:0] i_red_x,
    input  logic [COORD_W-1:0] i_red_y,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WORD_W-1:0]  o_out_data
);

    ser_state_t         state_q, state_d;
    word_cnt_t          cnt_q, cnt_d;
    logic [POINT_W-1:0] shift_q, shift_d;
    point_t             load_pt;
    logic               red_ready_c;

    // Padded point image loaded on accept.
    always_comb begin
        load_pt       = '0;
        load_pt.x     = i_red_x;
        load_pt.y     = i_red_y;
    end

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        red_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                red_ready_c = 1'b1;
                if (i_red_valid) begin
                    shift_d = load_pt;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_out_ready) begin
                    shift_d = {WORD_W'(0), shift_q[POINT_W-1:WORD_W]};
                    cnt_d   = cnt_q + word_cnt_t'(1);
                    if (cnt_q == LAST_WORD) begin
                        state_d = IDLE;
`ifdef SER_BACK2BACK_EN
                        // Last word leaving: take the next point on this edge.
                        red_ready_c = 1'b1;
                        if (i_red_valid) begin
                            shift_d = load_pt;
                            cnt_d   = '0;
                            state_d = SEND;
                        end
`endif
                    end
                end
            end
        endcase
    end

    // State, counter and shift register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Outputs decode flops only (except the optional last-word ready path).
    assign o_out_valid = (state_q == SEND);
    assign o_out_data  = shift_q[WORD_W-1:0];
    assign o_red_ready = red_ready_c;

endmodule

// File: tb/tb_point_serializer.sv
// Directed bench for point_serializer: reset values, hand-computed word
// streams, random backpressure, mid-stream reset and back-to-back points.
module tb_point_serializer;

    logic         i_clk;
    logic         i_rst;
    logic         i_red_valid;
    logic         o_red_ready;
    logic [254:0] i_red_x;
    logic [254:0] i_red_y;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [63:0]  o_out_data;

    int errors = 0;
    int checks = 0;

    point_serializer dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_red_valid (i_red_valid),
        .o_red_ready (o_red_ready),
        .i_red_x     (i_red_x),
        .i_red_y     (i_red_y),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pt_word(input logic [254:0] x, input logic [254:0] y, input int i);
        logic [511:0] p;
        p = {1'b0, y, 1'b0, x};
        return p[i*64 +: 64];
    endfunction

    // Offer one point in IDLE; returns just after the accept edge.
    task automatic send_point(input logic [254:0] x, input logic [254:0] y, input string tag);
        @(negedge i_clk);
        i_red_valid = 1'b1;
        i_red_x     = x;
        i_red_y     = y;
        #1;
        check({tag, " red_ready"}, 64'(o_red_ready), 64'd1);
        @(posedge i_clk);
        #1;
        i_red_valid = 1'b0;
        i_red_x     = ~x;
        i_red_y     = ~y;
    endtask

    // Collect nwords words; bp selects the 1,0,0,1 then random ready pattern.
    task automatic recv_words(input logic [63:0] exp [8], input bit bp, input int nwords, input string tag);
        int          n = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [63:0] held = '0;
        logic [3:0]  pat = 4'b1001;
        while (n < nwords && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
            if (!bp)            i_out_ready = 1'b1;
            else if (cyc <= 4)  i_out_ready = pat[4-cyc];
            else                i_out_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                check({tag, " stall valid"}, 64'(o_out_valid), 64'd1);
                check({tag, " stall data"}, o_out_data, held);
            end
            if (!bp)
                check($sformatf("%s valid c%0d", tag, cyc), 64'(o_out_valid), 64'd1);
            if (o_out_valid && i_out_ready) begin
                check($sformatf("%s word%0d", tag, n), o_out_data, exp[n]);
                n++;
            end
            stalled = o_out_valid && !i_out_ready;
            held    = o_out_data;
        end
        if (n < nwords)
            check({tag, " timeout words"}, 64'(n), 64'(nwords));
    endtask

    logic [63:0]  exp_w [8];
    logic [254:0] ax, ay, cx, cy;
    logic [63:0]  got_w [16];
    int           n_got, gaps, pend, pts;
    logic         acc;

    initial begin
        i_rst       = 1'b1;
        i_red_valid = 1'b0;
        i_red_x     = '0;
        i_red_y     = '0;
        i_out_ready = 1'b0;

        // Reset values
        #12;
        check("rst out_valid", 64'(o_out_valid), 64'd0);
        check("rst out_data", o_out_data, 64'd0);
        check("rst red_ready", 64'(o_red_ready), 64'd1);
        @(negedge i_clk);
        i_rst = 1'b0;

        // x=1, y=2, no backpressure
        exp_w = '{64'h1, 64'h0, 64'h0, 64'h0, 64'h2, 64'h0, 64'h0, 64'h0};
        send_point(255'd1, 255'd2, "p12");
        recv_words(exp_w, 1'b0, 8, "p12");
        @(negedge i_clk);
        #1;
        check("p12 ready after w7", 64'(o_red_ready), 64'd1);
        check("p12 idle valid", 64'(o_out_valid), 64'd0);

        // x = 2^255-20, y = 0x0123456789ABCDEF
        exp_w = '{64'hFFFFFFFFFFFFFFEC, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                  64'h7FFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0};
        ax = {255{1'b1}} - 255'd19;
        send_point(ax, 255'h0123456789ABCDEF, "pmax");
        recv_words(exp_w, 1'b0, 8, "pmax");

        // Random backpressure
        ax = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ay = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) exp_w[i] = pt_word(ax, ay, i);
        send_point(ax, ay, "bp");
        recv_words(exp_w, 1'b1, 8, "bp");
        @(negedge i_clk);
        i_out_ready = 1'b1;
        #1;
        check("bp no extra", 64'(o_out_valid), 64'd0);
        check("bp idle ready", 64'(o_red_ready), 64'd1);

        // Reset after word 3 accepted
        exp_w = '{64'h7, 64'h0, 64'h0, 64'h0, 64'h8, 64'h0, 64'h0, 64'h0};
        send_point(255'd7, 255'd8, "prst");
        recv_words(exp_w, 1'b0, 4, "prst");
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check("rst mid valid", 64'(o_out_valid), 64'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst release ready", 64'(o_red_ready), 64'd1);
        check("rst release valid", 64'(o_out_valid), 64'd0);
        exp_w = '{64'h5, 64'h0, 64'h0, 64'h0, 64'h6, 64'h0, 64'h0, 64'h0};
        send_point(255'd5, 255'd6, "p56");
        recv_words(exp_w, 1'b0, 8, "p56");

        // Back-to-back points
        ax = 255'hA;
        ay = 255'hB;
        cx = {$urandom, 223'h0} | 255'hC;
        cy = 255'hD;
        @(negedge i_clk);
        i_out_ready = 1'b1;
        i_red_valid = 1'b1;
        i_red_x     = ax;
        i_red_y     = ay;
        n_got = 0;
        gaps  = 0;
        pend  = 0;
        pts   = 0;
        for (int c = 0; c < 60 && n_got < 16; c++) begin
            if (c != 0) @(negedge i_clk);
            if (pend != 0) begin
                pts++;
                if (pts == 1) begin
                    i_red_x = cx;
                    i_red_y = cy;
                end else begin
                    i_red_valid = 1'b0;
                end
            end
            #1;
            acc  = i_red_valid && o_red_ready;
            pend = acc ? 1 : 0;
            if (o_out_valid) begin
                got_w[n_got] = o_out_data;
                n_got++;
            end else if (n_got > 0) begin
                gaps++;
            end
        end
        check("b2b words", 64'(n_got), 64'd16);
        for (int i = 0; i < 16 && i < n_got; i++)
            check($sformatf("b2b word%0d", i), got_w[i],
                  (i < 8) ? pt_word(ax, ay, i) : pt_word(cx, cy, i - 8));
`ifdef SER_BACK2BACK_EN
        check("b2b gaps", 64'(gaps), 64'd0);
`else
        check("b2b gaps", 64'(gaps), 64'd1);
`endif
        i_red_valid = 1'b0;
        @(negedge i_clk);
        #1;
        check("b2b end valid", 64'(o_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
